// File: rtl/load_align_unit.sv
// load_align_unit: multi-cycle load unit between the memory stage and the data
// memory port. Fetches one or two bus beats, merges them for loads that cross
// a beat boundary, and returns the sign/zero-extended result with its tag.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   Req/Addr/Funct3     load request (accepted when Req && Ready)
//   TagIn               destination tag captured on accept
//   Ready               high only while idle
//   MemReq/MemAddr      beat read request, held until MemAck
//   MemAck/MemRData     beat read response
//   Valid/RDOut/TagOut  one-cycle result pulse, data and tag held until next Valid
//   Fault               qualifies Valid: illegal Funct3 or forbidden misaligned load
module load_align_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MISALIGN_EN = 1,
  parameter int unsigned TAG_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [2:0]        Funct3,
  input  logic [TAG_W-1:0]  TagIn,
  output logic              Ready,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [XLEN-1:0]   MemRData,
  output logic              Valid,
  output logic [XLEN-1:0]   RDOut,
  output logic [TAG_W-1:0]  TagOut,
  output logic              Fault
);

  localparam int unsigned B     = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(B);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic [XLEN-1:0]     rd_q, rd_d;
  logic [TAG_W-1:0]    tag_out_q, tag_out_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic                cross_q, cross_d;
  logic [XLEN-1:0]     beat0_q, beat0_d;

  // Request decode
  logic [OFF_W-1:0] in_off;
  logic [3:0]       in_nbytes;
  logic             in_cross;
  logic             in_misalign;
  logic             in_illegal;
  logic             in_fault;

  always_comb begin
    in_off      = Addr[OFF_W-1:0];
    in_nbytes   = 4'(1) << Funct3[1:0];
    in_cross    = (5'(in_off) + 5'(in_nbytes)) > 5'(B);
    in_misalign = (in_off & OFF_W'(in_nbytes - 4'd1)) != '0;
    in_illegal  = (Funct3 == 3'b111) ||
                  ((XLEN == 32) && ((Funct3 == 3'b011) || (Funct3 == 3'b110)));
    in_fault    = in_illegal || ((MISALIGN_EN == 0) && in_misalign);
  end

  // Shift the beat pair down by the byte offset, keep the low bytes, extend.
  // The sign bit is isolated as the top bit of the size mask to avoid a
  // variable bit select wider than the data.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] pair,
                                              input logic [OFF_W-1:0]  off,
                                              input logic [1:0]        size,
                                              input logic              sgn);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   val;
    logic [XLEN-1:0]   mask;
    logic [6:0]        nbits;
    logic              msb;
    sh    = pair >> {off, 3'b000};
    val   = sh[XLEN-1:0];
    nbits = 7'(8) << size;
    mask  = (nbits >= 7'(XLEN)) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    msb   = |(val & (mask ^ (mask >> 1)));
    return (val & mask) | ({XLEN{sgn & msb}} & ~mask);
  endfunction

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = 1'b0;
    fault_d    = 1'b0;
    rd_d       = rd_q;
    tag_out_d  = tag_out_q;
    req_tag_d  = req_tag_q;
    off_d      = off_q;
    size_d     = size_q;
    sign_d     = sign_q;
    cross_d    = cross_q;
    beat0_d    = beat0_q;

    case (state_q)
      IDLE: begin
        if (Req && ready_q) begin
          req_tag_d = TagIn;
          if (in_fault) begin
            // Rejected without touching memory; report next cycle
            valid_d   = 1'b1;
            fault_d   = 1'b1;
            rd_d      = '0;
            tag_out_d = TagIn;
          end else begin
            state_d    = BEAT0;
            ready_d    = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = {Addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            off_d      = in_off;
            size_d     = Funct3[1:0];
            sign_d     = ~Funct3[2];
            cross_d    = in_cross;
          end
        end
      end

      BEAT0: begin
        if (MemAck) begin
          beat0_d = MemRData;
          if (cross_q) begin
            state_d    = BEAT1;
            mem_addr_d = mem_addr_q + ADDR_W'(B);
          end else begin
            state_d   = IDLE;
            ready_d   = 1'b1;
            mem_req_d = 1'b0;
            valid_d   = 1'b1;
            rd_d      = extract({{XLEN{1'b0}}, MemRData}, off_q, size_q, sign_q);
            tag_out_d = req_tag_q;
          end
        end
      end

      BEAT1: begin
        if (MemAck) begin
          state_d   = IDLE;
          ready_d   = 1'b1;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          rd_d      = extract({MemRData, beat0_q}, off_q, size_q, sign_q);
          tag_out_d = req_tag_q;
        end
      end

      default: begin
        state_d   = IDLE;
        ready_d   = 1'b1;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      rd_q       <= '0;
      tag_out_q  <= '0;
      req_tag_q  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      cross_q    <= 1'b0;
      beat0_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      rd_q       <= rd_d;
      tag_out_q  <= tag_out_d;
      req_tag_q  <= req_tag_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      cross_q    <= cross_d;
      beat0_q    <= beat0_d;
    end
  end

  assign Ready   = ready_q;
  assign MemReq  = mem_req_q;
  assign MemAddr = mem_addr_q;
  assign Valid   = valid_q;
  assign Fault   = fault_q;
  assign RDOut   = rd_q;
  assign TagOut  = tag_out_q;

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised multi-cycle load unit for the pipelined core. It sits between the memory stage and the data memory port. It accepts one load request, fetches one or two bus beats and merges them, so misaligned loads that cross a beat boundary are supported. It then returns the byte/half/word/double result, sign- or zero-extended, together with the destination tag.

Parameters:
XLEN, 32, data/bus width in bits; 32 or 64 only.
ADDR_W, 32, address width in bits.
MISALIGN_EN, 1, 1 = split boundary-crossing loads into two beats; 0 = raise Fault on any misaligned load.
TAG_W, 5, width of the destination-register tag carried through the unit.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
Req  in  1  load request; accepted when Req && Ready.
Addr  in  ADDR_W  byte address of the load.
Funct3  in  3  RISC-V load funct3: [1:0] size (0=B, 1=H, 2=W, 3=D); [2] unsigned.
TagIn  in  TAG_W  destination tag; captured on accept.
Ready  out  1  high only in IDLE.
MemReq  out  1  memory read request; held until MemAck.
MemAddr  out  ADDR_W  beat address, aligned to XLEN/8; held stable while MemReq is high.
MemAck  in  1  read data valid this cycle.
MemRData  in  XLEN  read data; sampled when MemReq && MemAck.
Valid  out  1  one-cycle result pulse.
RDOut  out  XLEN  extended load result; held until the next Valid.
TagOut  out  TAG_W  tag of the result; held with RDOut.
Fault  out  1  qualifies Valid; illegal Funct3, or misaligned load with MISALIGN_EN=0.

Behaviour:
- Reset: state IDLE; Ready=1 after release; MemReq, Valid, Fault = 0; MemAddr, RDOut, TagOut = 0.
- Reset asserted mid-operation: MemReq drops immediately (asynchronous); the in-flight load is discarded and never produces Valid.
- Definitions: B = XLEN/8; off = Addr mod B; nbytes = 1 << size.
- Beat crossing: cross = (off + nbytes > B).
- Illegal Funct3: 3'b111 always. Also 3'b011 and 3'b110 when XLEN=32.
- FSM states: IDLE, BEAT0, BEAT1.
- IDLE, accept, legal and permitted: latch base = Addr & ~(B-1), off, size, sign and tag.
  - Go to BEAT0 with MemReq=1 and MemAddr=base.
- IDLE, accept, illegal or misaligned-forbidden: no memory access; stay IDLE.
  - Next cycle: Valid=1, Fault=1, RDOut=0, TagOut=tag.
- BEAT0: wait for MemAck; capture beat0.
  - If cross: go to BEAT1 with MemAddr = base + B (wraps modulo 2^ADDR_W).
  - If not cross: go to IDLE; Valid=1 next cycle.
- BEAT1: wait for MemAck; capture beat1; go to IDLE; Valid=1 next cycle.
- MemReq deasserts in the cycle after the ack.
- Merge: the combined value {beat1, beat0} is shifted right by 8*off, and the low nbytes are taken.
  - Signed: replicate bit 8*nbytes-1. Unsigned: zero-fill.
  - Size W at XLEN=64 with unsigned = LWU.
- Latency with zero-wait ack: aligned load = Valid 2 cycles after accept; crossing load = 3 cycles.
- Ready rises together with Valid, so back-to-back requests are allowed. Req while not Ready is ignored.
- Valid and Fault are registered one-cycle pulses. Fault=0 whenever Valid is driven by a successful load.
- MemAck without MemReq is ignored.

Test Plan:
- XLEN=32, word 0x80FF0000 @0x1000, LB @0x1003 -> one beat at MemAddr=0x1000, RDOut=0xFFFFFF80, Valid 2 cycles after accept. LBU same address -> 0x00000080.
- Word 0x80011234 @0x1000, LH @0x1002 -> 0xFFFF8001; LHU -> 0x00008001.
- Words 0x44332211 @0x1000 and 0x88776655 @0x1004:
  - LW @0x1001 -> MemAddr 0x1000 then 0x1004, RDOut=0x55443322, Valid 3 cycles after accept.
  - LH @0x1003 -> 0x00005544.
- MemAck delayed 3 cycles on each beat -> MemReq and MemAddr stable throughout, Ready=0, exactly one Valid, correct data.
- Fault cases, each giving no MemReq, Valid=Fault=1 next cycle, RDOut=0:
  - Funct3=3'b011 at XLEN=32.
  - MISALIGN_EN=0 with LW @0x1002.
- Reset asserted during BEAT1 -> MemReq=0 the same cycle, no Valid, Ready=1 after release.
- LW @0xFFFFFFFE -> second MemAddr = 0x00000000.
- XLEN=64 checks:
  - LD @0x...5 crossing -> correct 8-byte merge.
  - LWU with bit 31 set -> upper 32 bits zero.
